fp2int_seq: RTL and testbench
=============================

FP2INT_SEQ -- requirements
Module: fp2int_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request conversion; sampled only while idle.
REQ-004 SHALL have port a, input, 32 bits: IEEE-754 single operand; sampled with start.
REQ-005 SHALL have port rm, input, 2 bits: rounding mode, sampled with start; 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero.
REQ-006 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse; d, invalid and inexact valid.
REQ-008 SHALL have port d, output, 32 bits: signed two's-complement result.
REQ-009 SHALL have port invalid, output, 1 bit: NaN, infinity or out-of-range operand.
REQ-010 SHALL have port inexact, output, 1 bit: nonzero bits discarded by rounding.

Function
REQ-011 SHALL implement three behaviours:
- idle: start accepted on the edge where busy=0 and start=1.
- SHIFT: one bit per cycle.
- final round/output.
REQ-012 SHALL ignore start while busy=1; a and rm are latched internally at acceptance.
REQ-013 SHALL, at acceptance, form m24 = {hidden, a[22:0]}, with hidden = |a[30:23], and e = max(a[30:23], 1).
REQ-014 SHALL load shift count N:
- e>=158, or NaN/inf: N=0, special path.
- 150<=e<=157: left shift, N=e-150.
- e<150: right shift, N=min(150-e, 25).
REQ-015 SHALL, for each right-shift cycle, shift magnitude right 1 bit into guard, with old guard ORed into sticky.
REQ-016 SHALL, for each left-shift cycle, shift magnitude left 1 bit; guard and sticky stay 0.
REQ-017 SHALL round in the cycle the counter is 0, using magnitude q, guard g, sticky s and sign a[31]:
- 00: inc = g&(s|q[0]).
- 01: inc = (g|s)&sign.
- 10: inc = (g|s)&~sign.
- 11: inc = 0.
REQ-018 SHALL output d = sign ? -(q+inc) : (q+inc).
REQ-019 SHALL set inexact = g|s for non-invalid results, else 0.
REQ-020 SHALL handle special operands:
- NaN: d=32'h7FFFFFFF, invalid=1.
- +inf, or positive with e>=158: d=32'h7FFFFFFF, invalid=1.
- -inf, or negative with e>=158 except exactly 32'hCF000000: d=32'h80000000, invalid=1.
- 32'hCF000000: d=32'h80000000, invalid=0, inexact=0.
REQ-021 SHALL meet timing:
- Acceptance edge = edge 1.
- Shift edges 2..N+1.
- Results registered and done=1 after edge N+2, for exactly one cycle.
- busy=1 after edge 1 through the edge that raises done, then 0.
REQ-022 SHALL accept a new start on the same cycle done=1, since busy=0 then (back-to-back).
REQ-023 SHALL hold d, invalid and inexact stable between done pulses.
REQ-024 SHALL convert zero and denormals through the normal path (N=25); +/-0 yields d=0, inexact=0.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear to: idle, busy=0, done=0, d=0, invalid=0, inexact=0, counter=0.
REQ-026 SHALL, on rst asserted mid-conversion, abort the conversion; no done pulse is produced for it.
REQ-027 SHALL take rst priority over start on the same edge.

Verification
REQ-028 SHALL cover a=32'h3FC00000 (1.5), rm=00 -> d=2, inexact=1, invalid=0, done 25 cycles after acceptance (N=23).
REQ-029 SHALL cover a=32'h40200000 (2.5): rm=00 -> d=2; rm=11 -> d=2; a=32'hC0200000, rm=01 -> d=32'hFFFFFFFD; all inexact=1.
REQ-030 SHALL cover a=32'h4F000000 -> d=32'h7FFFFFFF, invalid=1, done 2 cycles after acceptance; a=32'hCF000000 -> d=32'h80000000, invalid=0.
REQ-031 SHALL cover a=32'h7FC00000 (NaN) -> d=32'h7FFFFFFF, invalid=1; a=32'h00000001, rm=10 -> d=1, inexact=1.
REQ-032 SHALL cover start pulsed while busy -> ignored, first result unchanged; start held high -> next conversion accepted in the done cycle.
REQ-033 SHALL cover rst asserted 5 cycles into a conversion -> busy=0, d=0, no done pulse; next start converts normally.

Source files
------------

// File: rtl/fp2int_seq.sv
// Purpose : IEEE-754 single to signed 32-bit integer converter, one shift bit per cycle.
// Latency : result and done appear N+2 edges after the acceptance edge (N = 0..25).
// Backpressure: none; start is only taken while busy=0, and a start during busy is dropped.
// Ports   : clk, rst (sync, active-high) | start, a[31:0], rm[1:0] in |
//           busy, done (1-cycle pulse), d[31:0], invalid, inexact out
module fp2int_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [1:0]  rm,
   output logic        busy,
   output logic        done,
   output logic [31:0] d,
   output logic        invalid,
   output logic        inexact
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] mag_q, mag_d;
   logic        g_q, g_d;
   logic        s_q, s_d;
   logic        sign_q, sign_d;
   logic [1:0]  rm_q, rm_d;
   logic        left_q, left_d;
   logic        spec_q, spec_d;
   logic        spec_pos_q, spec_pos_d;
   logic        spec_inv_q, spec_inv_d;
   logic        done_q, done_d;
   logic [31:0] d_q, d_d;
   logic        invalid_q, invalid_d;
   logic        inexact_q, inexact_d;

   // Operand decode, only used on the acceptance edge.
   logic [7:0]  exp_raw;
   logic [7:0]  e_val;
   logic [7:0]  rdiff;
   logic        hidden;
   logic [23:0] m24;
   logic        spec_val;
   logic        left_val;
   logic [4:0]  n_val;
   logic        spec_pos_val;
   logic        spec_inv_val;

   always_comb begin
      exp_raw      = a[30:23];
      hidden       = |exp_raw;
      e_val        = hidden ? exp_raw : 8'd1;
      m24          = {hidden, a[22:0]};
      // e >= 158 already covers NaN/inf (exponent 255).
      spec_val     = (e_val >= 8'd158);
      left_val     = (e_val >= 8'd150);
      rdiff        = 8'd150 - e_val;
      n_val        = 5'd0;
      spec_pos_val = 1'b1;
      spec_inv_val = 1'b1;
      if (spec_val) begin
         n_val = 5'd0;
      end else if (left_val) begin
         n_val = 5'(e_val - 8'd150);
      end else begin
         // Beyond 25 right shifts every bit is already below the guard.
         n_val = (rdiff > 8'd25) ? 5'd25 : rdiff[4:0];
      end
      if ((exp_raw == 8'hFF) && (a[22:0] != 23'd0)) begin
         spec_pos_val = 1'b1;               // NaN saturates positive regardless of sign
         spec_inv_val = 1'b1;
      end else if (!a[31]) begin
         spec_pos_val = 1'b1;
         spec_inv_val = 1'b1;
      end else if (a == 32'hCF00_0000) begin
         spec_pos_val = 1'b0;               // exactly -2^31 is representable
         spec_inv_val = 1'b0;
      end else begin
         spec_pos_val = 1'b0;
         spec_inv_val = 1'b1;
      end
   end

   // Rounding increment and signed result from the final magnitude/guard/sticky.
   logic        inc;
   logic [31:0] sum;
   logic [31:0] res;

   always_comb begin
      unique case (rm_q)
         2'b00:   inc = g_q & (s_q | mag_q[0]);
         2'b01:   inc = (g_q | s_q) & sign_q;
         2'b10:   inc = (g_q | s_q) & ~sign_q;
         default: inc = 1'b0;
      endcase
      sum = mag_q + {31'd0, inc};
      res = sign_q ? (32'd0 - sum) : sum;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mag_d      = mag_q;
      g_d        = g_q;
      s_d        = s_q;
      sign_d     = sign_q;
      rm_d       = rm_q;
      left_d     = left_q;
      spec_d     = spec_q;
      spec_pos_d = spec_pos_q;
      spec_inv_d = spec_inv_q;
      done_d     = 1'b0;
      d_d        = d_q;
      invalid_d  = invalid_q;
      inexact_d  = inexact_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d      = n_val;
               mag_d      = {8'd0, m24};
               g_d        = 1'b0;
               s_d        = 1'b0;
               sign_d     = a[31];
               rm_d       = rm;
               left_d     = left_val;
               spec_d     = spec_val;
               spec_pos_d = spec_pos_val;
               spec_inv_d = spec_inv_val;
               state_d    = (n_val == 5'd0) ? S_ROUND : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (left_q) begin
               mag_d = {mag_q[30:0], 1'b0};
            end else begin
               mag_d = {1'b0, mag_q[31:1]};
               g_d   = mag_q[0];
               s_d   = s_q | g_q;
            end
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (spec_q) begin
               d_d       = spec_pos_q ? 32'h7FFF_FFFF : 32'h8000_0000;
               invalid_d = spec_inv_q;
               inexact_d = 1'b0;
            end else begin
               d_d       = res;
               invalid_d = 1'b0;
               inexact_d = g_q | s_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 5'd0;
         mag_q      <= 32'd0;
         g_q        <= 1'b0;
         s_q        <= 1'b0;
         sign_q     <= 1'b0;
         rm_q       <= 2'd0;
         left_q     <= 1'b0;
         spec_q     <= 1'b0;
         spec_pos_q <= 1'b0;
         spec_inv_q <= 1'b0;
         done_q     <= 1'b0;
         d_q        <= 32'd0;
         invalid_q  <= 1'b0;
         inexact_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mag_q      <= mag_d;
         g_q        <= g_d;
         s_q        <= s_d;
         sign_q     <= sign_d;
         rm_q       <= rm_d;
         left_q     <= left_d;
         spec_q     <= spec_d;
         spec_pos_q <= spec_pos_d;
         spec_inv_q <= spec_inv_d;
         done_q     <= done_d;
         d_q        <= d_d;
         invalid_q  <= invalid_d;
         inexact_q  <= inexact_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign d       = d_q;
   assign invalid = invalid_q;
   assign inexact = inexact_q;

endmodule

// File: tb/tb_fp2int_seq.sv
// Purpose : self-checking bench for fp2int_seq: directed table, corner sequences, random vs model.
// Latency : measured as the edge index (acceptance edge = 1) at which done is first seen.
// Backpressure: start is driven only while the converter is expected idle, except where busy is probed.
module tb_fp2int_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [1:0]  rm;
   logic        busy;
   logic        done;
   logic [31:0] d;
   logic        invalid;
   logic        inexact;

   int checks = 0;
   int errors = 0;

   fp2int_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .rm      (rm),
      .busy    (busy),
      .done    (done),
      .d       (d),
      .invalid (invalid),
      .inexact (inexact)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [1:0]  rm;
      logic [31:0] d;
      bit          inv;
      bit          inx;
      int          lat;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Waits for done with a cycle budget; lat returns the edge index of done (40 = timed out).
   task automatic wait_done(input int lat_in, output int lat);
      lat = lat_in;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run(input logic [31:0] av, input logic [1:0] rmv,
                      output logic [31:0] dv, output bit iv, output bit xv, output int lat);
      @(negedge clk);
      a = av; rm = rmv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1, lat);
      dv = d; iv = invalid; xv = inexact;
   endtask

   // Reference: exact value sig*2^sc, rounded by comparing the discarded remainder to one half.
   function automatic void model(input logic [31:0] av, input logic [1:0] rmv,
                                 output logic [31:0] dv, output bit iv, output bit xv, output int lat);
      int     ex, ee, sc, k;
      bit     sgn, gt, eq, nz, up;
      longint sig, q, rem, half, mag, val;
      ex  = int'(av[30:23]);
      sgn = av[31];
      ee  = (ex == 0) ? 1 : ex;
      if (ex == 255 || ee >= 158) lat = 2;
      else if (ee >= 150)         lat = ee - 150 + 2;
      else                        lat = ((150 - ee) > 25 ? 25 : (150 - ee)) + 2;
      gt = 0; eq = 0; nz = 0; q = 0;
      if (ex == 255) begin
         iv = 1; xv = 0;
         dv = (av[22:0] != 0 || !sgn) ? 32'h7FFFFFFF : 32'h80000000;
         return;
      end
      sig = (ex == 0) ? longint'(av[22:0]) : (longint'(av[22:0]) + 64'sd8388608);
      sc  = ee - 150;
      if (sc > 8) begin
         q = 64'sh1_0000_0000;                     // certainly out of range
      end else if (sc >= 0) begin
         q = sig << sc;
      end else begin
         k = -sc;
         if (k > 40) begin
            q  = 0;
            nz = (sig != 0);
         end else begin
            q    = sig >> k;
            rem  = sig - (q << k);
            half = 64'sd1 << (k - 1);
            gt   = rem > half;
            eq   = rem == half;
            nz   = rem != 0;
         end
      end
      case (rmv)
         2'd0:    up = gt || (eq && q[0]);
         2'd1:    up = nz && sgn;
         2'd2:    up = nz && !sgn;
         default: up = 0;
      endcase
      mag = q + (up ? 64'sd1 : 64'sd0);
      val = sgn ? -mag : mag;
      if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
         iv = 1; xv = 0;
         dv = sgn ? 32'h80000000 : 32'h7FFFFFFF;
      end else begin
         iv = 0; xv = nz;
         dv = val[31:0];
      end
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] dv, md, ra;
      bit          iv, xv, mi, mx;
      int          lat, mlat, ndone;
      logic [1:0]  rr;

      rst = 1'b1; start = 1'b0; a = 32'd0; rm = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_d", d, 32'd0);
      chk("rst_inv", {31'd0, invalid}, 32'd0);
      chk("rst_inx", {31'd0, inexact}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table: a, rm, d, invalid, inexact, done edge index.
      vq.push_back('{32'h3FC00000, 2'd0, 32'h00000002, 1'b0, 1'b1, 25});
      vq.push_back('{32'h40200000, 2'd0, 32'h00000002, 1'b0, 1'b1, 24});
      vq.push_back('{32'h40200000, 2'd3, 32'h00000002, 1'b0, 1'b1, 24});
      vq.push_back('{32'hC0200000, 2'd1, 32'hFFFFFFFD, 1'b0, 1'b1, 24});
      vq.push_back('{32'h4F000000, 2'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 2});
      vq.push_back('{32'hCF000000, 2'd0, 32'h80000000, 1'b0, 1'b0, 2});
      vq.push_back('{32'hCF000001, 2'd0, 32'h80000000, 1'b1, 1'b0, 2});
      vq.push_back('{32'h7FC00000, 2'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 2});
      vq.push_back('{32'h7F800000, 2'd3, 32'h7FFFFFFF, 1'b1, 1'b0, 2});
      vq.push_back('{32'hFF800000, 2'd2, 32'h80000000, 1'b1, 1'b0, 2});
      vq.push_back('{32'h00000001, 2'd2, 32'h00000001, 1'b0, 1'b1, 27});
      vq.push_back('{32'h00000000, 2'd0, 32'h00000000, 1'b0, 1'b0, 27});
      vq.push_back('{32'h80000000, 2'd1, 32'h00000000, 1'b0, 1'b0, 27});
      vq.push_back('{32'h4EFFFFFF, 2'd0, 32'h7FFFFF80, 1'b0, 1'b0, 9});
      vq.push_back('{32'hCEFFFFFF, 2'd1, 32'h80000080, 1'b0, 1'b0, 9});
      vq.push_back('{32'h4B000000, 2'd0, 32'h00800000, 1'b0, 1'b0, 2});
      vq.push_back('{32'h3F000000, 2'd0, 32'h00000000, 1'b0, 1'b1, 26});
      vq.push_back('{32'hBF000000, 2'd1, 32'hFFFFFFFF, 1'b0, 1'b1, 26});
      vq.push_back('{32'h3F400000, 2'd0, 32'h00000001, 1'b0, 1'b1, 26});
      vq.push_back('{32'h3F800000, 2'd2, 32'h00000001, 1'b0, 1'b0, 25});

      foreach (vq[i]) begin
         run(vq[i].a, vq[i].rm, dv, iv, xv, lat);
         chk($sformatf("vec%0d_lat", i), lat, vq[i].lat);
         chk($sformatf("vec%0d_d", i), dv, vq[i].d);
         chk($sformatf("vec%0d_inv", i), {31'd0, iv}, {31'd0, vq[i].inv});
         chk($sformatf("vec%0d_inx", i), {31'd0, xv}, {31'd0, vq[i].inx});
         @(posedge clk); #1;
         chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
         chk($sformatf("vec%0d_busy_after", i), {31'd0, busy}, 32'd0);
         chk($sformatf("vec%0d_hold_d", i), d, vq[i].d);
      end

      // start pulsed while busy is ignored.
      @(negedge clk);
      a = 32'h3FC00000; rm = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 32'h4F000000; rm = 2'd3;
      lat = 1;
      repeat (3) begin @(posedge clk); #1; lat++; end
      chk("ign_busy", {31'd0, busy}, 32'd1);
      start = 1'b1;
      @(posedge clk); #1; lat++;
      start = 1'b0;
      wait_done(lat, lat);
      chk("ign_lat", lat, 25);
      chk("ign_d", d, 32'h00000002);
      chk("ign_inv", {31'd0, invalid}, 32'd0);
      @(posedge clk); #1;
      chk("ign_no_second", {31'd0, busy | done}, 32'd0);

      // start held high: second conversion accepted in the done cycle.
      @(negedge clk);
      a = 32'h3FC00000; rm = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      a = 32'hC0200000; rm = 2'd1;
      wait_done(1, lat);
      chk("b2b_lat1", lat, 25);
      chk("b2b_d1", d, 32'h00000002);
      @(posedge clk); #1;
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      start = 1'b0;
      wait_done(1, lat);
      chk("b2b_lat2", lat, 24);
      chk("b2b_d2", d, 32'hFFFFFFFD);
      chk("b2b_inx2", {31'd0, inexact}, 32'd1);

      // Reset five cycles into a conversion aborts it.
      @(negedge clk);
      a = 32'h3FC00000; rm = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_d", d, 32'd0);
      chk("abort_inx", {31'd0, inexact}, 32'd0);
      ndone = 0;
      repeat (30) begin @(posedge clk); #1; if (done) ndone++; end
      chk("abort_no_done", ndone, 0);
      run(32'h40200000, 2'd0, dv, iv, xv, lat);
      chk("post_abort_lat", lat, 24);
      chk("post_abort_d", dv, 32'h00000002);

      // Reset wins over start on the same edge.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; a = 32'h3FC00000;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rst_prio_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("rst_prio_idle", {31'd0, busy | done}, 32'd0);

      // Random operands, exponent biased toward the interesting ranges.
      for (int n = 0; n < 300; n++) begin
         ra[31]    = 1'($urandom_range(0, 1));
         ra[22:0]  = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
         case ($urandom_range(0, 5))
            0:       ra[30:23] = 8'd0;
            1:       ra[30:23] = 8'hFF;
            2:       ra[30:23] = 8'($urandom_range(100, 149));
            3:       ra[30:23] = 8'($urandom_range(150, 160));
            4:       ra[30:23] = 8'($urandom_range(120, 135));
            default: ra[30:23] = 8'($urandom);
         endcase
         rr = 2'($urandom_range(0, 3));
         model(ra, rr, md, mi, mx, mlat);
         run(ra, rr, dv, iv, xv, lat);
         chk($sformatf("rnd%0d_lat a=%h", n, ra), lat, mlat);
         chk($sformatf("rnd%0d_d a=%h rm=%0d", n, ra, rr), dv, md);
         chk($sformatf("rnd%0d_inv a=%h", n, ra), {31'd0, iv}, {31'd0, mi});
         chk($sformatf("rnd%0d_inx a=%h rm=%0d", n, ra, rr), {31'd0, xv}, {31'd0, mx});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
